// File: rtl/lb_arb_defs.sv
// lb_arb_defs: shared state encodings and read-latency limits for the lb_arb family
package lb_arb_defs;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 7;
endpackage

// File: rtl/lb_arb2_if.sv
// lb_arb2_if: shared local-bus slave port
interface lb_arb2_if #(parameter int AW = 24, parameter int DW = 32);
  logic [AW-1:0] lb_addr;
  logic          lb_strobe;
  logic          lb_rd;
  logic [DW-1:0] lb_wdata;
  logic [DW-1:0] lb_rdata;
  modport master (output lb_addr, lb_strobe, lb_rd, lb_wdata, input lb_rdata);
  modport slave (input lb_addr, lb_strobe, lb_rd, lb_wdata, output lb_rdata);
endinterface

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick; on a tie the side not granted last wins
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);
  always_comb begin
    valid  = |req;
    winner = &req ? ~last : req[1];
  end
endmodule

// File: rtl/lb_arb2.sv
// lb_arb2: two-requester round-robin arbiter onto a single local-bus slave
module lb_arb2
  import lb_arb_defs::*;
#(
  parameter int AW     = 24,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          rd0,
  input  logic          rd1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  lb_arb2_if.master     lb,
  output logic          busy,
  output logic          grant_id,
  output logic [15:0]   count0,
  output logic [15:0]   count1
);
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_lat_chk
    $error("lb_arb2: RD_LAT out of range");
  end
  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);
  state_t        state, nxt;
  logic          armed, last, pick_v, pick_w, take;
  logic [2:0]    cnt;
  logic [AW-1:0] addr_q;
  logic          rd_q;
  logic [DW-1:0] wdata_q;
  rr_pick2 u_pick (.req({req1, req0}), .last(last), .valid(pick_v), .winner(pick_w));
  always_comb begin
    take         = state == IDLE && armed && pick_v;
    nxt          = state == IDLE  ? (take ? ISSUE : IDLE) :
                   state == ISSUE ? (rd_q ? WAIT : DONE) :
                   state == WAIT  ? (cnt == 3'd0 ? DONE : WAIT) : IDLE;
    lb.lb_strobe = state == ISSUE;
    lb.lb_addr   = addr_q;
    lb.lb_rd     = rd_q;
    lb.lb_wdata  = wdata_q;
    done0        = state == DONE && !grant_id;
    done1        = state == DONE && grant_id;
    busy         = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // the WAIT countdown runs LAT_M1..0, so read data is captured RD_LAT cycles after the strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      armed    <= 1'b0;
      last     <= 1'b1;
      grant_id <= 1'b0;
      cnt      <= 3'd0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wdata_q  <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
      count0   <= '0;
      count1   <= '0;
    end else begin
      armed <= 1'b1;
      if (take) begin
        grant_id <= pick_w;
        last     <= pick_w;
        addr_q   <= pick_w ? addr1 : addr0;
        rd_q     <= pick_w ? rd1 : rd0;
        wdata_q  <= pick_w ? wdata1 : wdata0;
      end
      if (state == ISSUE) cnt <= LAT_M1;
      else if (state == WAIT) cnt <= cnt - 3'd1;
      if (state == WAIT && cnt == 3'd0) begin
        if (grant_id) rdata1 <= lb.lb_rdata;
        else rdata0 <= lb.lb_rdata;
      end
      if (state == DONE) begin
        if (grant_id) count1 <= count1 + 16'd1;
        else count0 <= count0 + 16'd1;
      end
    end
endmodule
